// File: rtl/cache_mem_pkg.sv
// Shared constants for the I/D cache refill arbiter: FSM encoding, line geometry
// and grant encoding.
package cache_mem_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBeat = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam int unsigned ILineW = 128;
  localparam int unsigned DLineW = 64;
  localparam int unsigned IBeats = 4;
  localparam int unsigned DBeats = 2;

  localparam logic GntI = 1'b0;
  localparam logic GntD = 1'b1;

  // Index of the final beat of a burst for the given side.
  function automatic logic [1:0] last_beat(input logic side);
    return (side == GntD) ? 2'(DBeats - 1) : 2'(IBeats - 1);
  endfunction

endpackage

// File: rtl/cache_rr_arbiter.sv
// Two-requester round-robin picker; on a tie the side not granted last time wins.
module cache_rr_arbiter
  import cache_mem_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic take_i,
  output logic grant_valid_o,
  output logic grant_o
);

  logic last_q, last_d;

  always_comb begin
    grant_valid_o = i_req_i | d_req_i;
    grant_o       = GntI;
    if (i_req_i && d_req_i) begin
      grant_o = (last_q == GntI) ? GntD : GntI;
    end else if (d_req_i) begin
      grant_o = GntD;
    end
  end

  always_comb begin
    last_d = last_q;
    if (take_i && grant_valid_o) begin
      last_d = grant_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= GntI;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates iCache and dCache misses onto a single word-wide memory port, running
// 4-beat I refills and 2-beat D refills/writebacks as back-to-back bursts.
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 20
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                i_req,
  input  logic [31:0]         i_addr,
  output logic [ILineW-1:0]   i_line,
  output logic                i_dready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [31:0]         d_addr,
  input  logic [63:0]         d_wdata,
  output logic [DLineW-1:0]   d_line,
  output logic                d_dready,
  output logic [31:0]         mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ack,
  output logic                busy
);

  logic [1:0]        state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic              side_q, side_d;
  logic              we_q, we_d;
  logic [31:0]       base_q, base_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [ILineW-1:0] fill_q, fill_d;
  logic [ILineW-1:0] i_line_q, i_line_d;
  logic [DLineW-1:0] d_line_q, d_line_d;

  logic              grant_valid;
  logic              grant;
  logic              take;
  logic [ILineW-1:0] fill_next;
  logic              in_beat;

  // Low address bits select within the line and the latency is a bench-side figure.
  logic unused_bits;
  assign unused_bits = ^{i_addr[3:0], d_addr[2:0], (MEM_LATENCY != 0)};

  assign take    = (state_q == StIdle);
  assign in_beat = (state_q == StBeat);

  cache_rr_arbiter u_rr (
    .clk_i        (CLK),
    .rst_ni       (RSTn),
    .i_req_i      (i_req),
    .d_req_i      (d_req),
    .take_i       (take),
    .grant_valid_o(grant_valid),
    .grant_o      (grant)
  );

  // Both sides fill word slots from the top of the buffer, so a D line is its upper half.
  always_comb begin
    fill_next = fill_q;
    unique case (beat_q)
      2'd0:    fill_next[127:96] = mem_rdata;
      2'd1:    fill_next[95:64]  = mem_rdata;
      2'd2:    fill_next[63:32]  = mem_rdata;
      default: fill_next[31:0]   = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    side_d   = side_q;
    we_d     = we_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    fill_d   = fill_q;
    i_line_d = i_line_q;
    d_line_d = d_line_q;

    case (state_q)
      StIdle: begin
        if (grant_valid) begin
          side_d  = grant;
          beat_d  = 2'd0;
          state_d = StBeat;
          if (grant == GntI) begin
            base_d = {i_addr[31:4], 4'b0};
            we_d   = 1'b0;
          end else begin
            base_d  = {d_addr[31:3], 3'b0};
            we_d    = d_we;
            wdata_d = d_wdata;
          end
        end
      end
      StBeat: begin
        if (mem_ack) begin
          if (!we_q) begin
            fill_d = fill_next;
          end
          if (beat_q == last_beat(side_q)) begin
            state_d = StDone;
            beat_d  = 2'd0;
            if (!we_q) begin
              if (side_q == GntI) begin
                i_line_d = fill_next;
              end else begin
                d_line_d = fill_next[ILineW-1 -: DLineW];
              end
            end
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        beat_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q  <= StIdle;
      beat_q   <= 2'd0;
      side_q   <= GntI;
      we_q     <= 1'b0;
      base_q   <= '0;
      wdata_q  <= '0;
      fill_q   <= '0;
      i_line_q <= '0;
      d_line_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      side_q   <= side_d;
      we_q     <= we_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      fill_q   <= fill_d;
      i_line_q <= i_line_d;
      d_line_q <= d_line_d;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = in_beat & ~we_q;
    mem_wr    = in_beat & we_q;
    if (in_beat) begin
      mem_addr = base_q + {28'd0, beat_q, 2'b00};
      if (we_q) begin
        mem_wdata = (beat_q == 2'd0) ? wdata_q[63:32] : wdata_q[31:0];
      end
    end
  end

  assign i_dready = (state_q == StDone) && (side_q == GntI);
  assign d_dready = (state_q == StDone) && (side_q == GntD);
  assign busy     = (state_q != StIdle);
  assign i_line   = i_line_q;
  assign d_line   = d_line_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboarded bench: expected memory beats and refill lines are queued as requests
// are raised, and checked when the memory port acks or a dready pulse appears.
module tb_cache_mem_arbiter;

  logic          CLK;
  logic          RSTn;
  logic          i_req;
  logic [31:0]   i_addr;
  logic [127:0]  i_line;
  logic          i_dready;
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [63:0]   d_wdata;
  logic [63:0]   d_line;
  logic          d_dready;
  logic [31:0]   mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;
  logic          busy;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } beat_t;

  beat_t        exp_beats[$];
  logic [127:0] exp_i_q[$];
  logic [63:0]  exp_d_q[$];
  bit           grant_order[$];
  logic [127:0] exp_i_line;
  logic [63:0]  exp_d_line;

  int total;
  int bad;
  int lat;
  int wait_cnt;
  int ack_count;
  int i_pulses;
  int d_pulses;
  bit spurious;

  cache_mem_arbiter #(.MEM_LATENCY(20)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_line   (i_line),
    .i_dready (i_dready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_line   (d_line),
    .d_dready (d_dready),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .busy     (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16] ^ 16'hC3A5};
  endfunction

  task automatic push_i(input logic [31:0] base);
    for (int k = 0; k < 4; k++) begin
      exp_beats.push_back('{addr: base + 32'(4 * k), wr: 1'b0, wdata: 32'h0});
    end
    exp_i_line = {mem_word(base), mem_word(base + 4), mem_word(base + 8), mem_word(base + 12)};
    exp_i_q.push_back(exp_i_line);
  endtask

  task automatic push_d_rd(input logic [31:0] base);
    exp_beats.push_back('{addr: base, wr: 1'b0, wdata: 32'h0});
    exp_beats.push_back('{addr: base + 4, wr: 1'b0, wdata: 32'h0});
    exp_d_line = {mem_word(base), mem_word(base + 4)};
    exp_d_q.push_back(exp_d_line);
  endtask

  // Memory model: each beat is acked after 'lat' strobe cycles (lat=1 is zero-wait).
  initial begin
    beat_t e;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(negedge CLK);
      if (mem_rd || mem_wr) begin
        total++;
        if (mem_rd && mem_wr) begin
          bad++;
          $display("FAIL strobe_exclusive: rd=%0b wr=%0b want not both", mem_rd, mem_wr);
        end
      end
      if (spurious) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end else if (mem_rd || mem_wr) begin
        wait_cnt++;
        if (wait_cnt >= lat) begin
          wait_cnt  = 0;
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          ack_count++;
          total++;
          if (exp_beats.size() == 0) begin
            bad++;
            $display("FAIL beat_unexpected: addr=%0h wr=%0b want no beat", mem_addr, mem_wr);
          end else begin
            e = exp_beats.pop_front();
            if (mem_addr !== e.addr || mem_wr !== e.wr || (e.wr && mem_wdata !== e.wdata)) begin
              bad++;
              $display("FAIL beat: addr=%0h wr=%0b wdata=%0h want addr=%0h wr=%0b wdata=%0h",
                       mem_addr, mem_wr, mem_wdata, e.addr, e.wr, e.wdata);
            end
          end
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        wait_cnt = 0;
        mem_ack  = 1'b0;
      end
    end
  end

  // dready monitor: checks the delivered line and releases the request.
  initial begin
    logic [127:0] ei;
    logic [63:0]  ed;
    i_pulses = 0;
    d_pulses = 0;
    forever begin
      @(negedge CLK);
      if (i_dready) begin
        i_pulses++;
        grant_order.push_back(1'b0);
        i_req = 1'b0;
        total++;
        if (exp_i_q.size() == 0) begin
          bad++;
          $display("FAIL i_dready_unexpected: line=%0h want no pulse", i_line);
        end else begin
          ei = exp_i_q.pop_front();
          if (i_line !== ei) begin
            bad++;
            $display("FAIL i_line: got %0h want %0h", i_line, ei);
          end
        end
      end
      if (d_dready) begin
        d_pulses++;
        grant_order.push_back(1'b1);
        d_req = 1'b0;
        total++;
        if (exp_d_q.size() == 0) begin
          bad++;
          $display("FAIL d_dready_unexpected: line=%0h want no pulse", d_line);
        end else begin
          ed = exp_d_q.pop_front();
          if (d_line !== ed) begin
            bad++;
            $display("FAIL d_line: got %0h want %0h", d_line, ed);
          end
        end
      end
    end
  end

  task automatic wait_quiet(input int max_cycles, output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge CLK);
      if (!busy && !i_req && !d_req) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    total++;
    if (busy !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: busy=%0b rd=%0b wr=%0b want 0", busy, mem_rd, mem_wr);
    end
    total++;
    if (i_dready !== 1'b0 || d_dready !== 1'b0) begin
      bad++;
      $display("FAIL reset_dready: i=%0b d=%0b want 0", i_dready, d_dready);
    end
    total++;
    if (i_line !== 128'h0 || d_line !== 64'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: i_line=%0h d_line=%0h addr=%0h wdata=%0h want 0",
               i_line, d_line, mem_addr, mem_wdata);
    end
    RSTn = 1'b1;
  endtask

  task automatic test_i_refill();
    int i0, d0;
    bit to;
    lat = 3;
    i0  = i_pulses;
    d0  = d_pulses;
    push_i(32'h0000_1230);
    @(negedge CLK);
    i_addr = 32'h0000_1234;
    i_req  = 1'b1;
    wait_quiet(200, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL i_refill_timeout: busy=%0b want idle", busy);
    end
    total++;
    if (i_pulses - i0 != 1 || d_pulses != d0) begin
      bad++;
      $display("FAIL i_refill_pulses: i=%0d d=%0d want 1 0", i_pulses - i0, d_pulses - d0);
    end
    total++;
    if (exp_beats.size() != 0) begin
      bad++;
      $display("FAIL i_refill_beats: left=%0d want 0", exp_beats.size());
    end
    repeat (2) @(negedge CLK);
    total++;
    if (i_line !== exp_i_line) begin
      bad++;
      $display("FAIL i_line_hold: got %0h want %0h", i_line, exp_i_line);
    end
  endtask

  task automatic test_tie();
    bit to;
    bit first, second;
    lat = 2;
    for (int round = 0; round < 2; round++) begin
      grant_order.delete();
      push_d_rd(round == 0 ? 32'h0000_3008 : 32'h0000_5000);
      push_i(round == 0 ? 32'h0000_2000 : 32'h0000_4010);
      @(negedge CLK);
      d_addr = (round == 0) ? 32'h0000_300C : 32'h0000_5004;
      d_we   = 1'b0;
      i_addr = (round == 0) ? 32'h0000_2008 : 32'h0000_401C;
      i_req  = 1'b1;
      d_req  = 1'b1;
      wait_quiet(300, to);
      total++;
      if (to || grant_order.size() != 2) begin
        bad++;
        $display("FAIL tie_grants: timeout=%0b grants=%0d want 0 2", to, grant_order.size());
      end else begin
        first  = grant_order[0];
        second = grant_order[1];
        total++;
        if (first !== 1'b1 || second !== 1'b0) begin
          bad++;
          $display("FAIL tie_order: got %0b,%0b want D(1),I(0)", first, second);
        end
      end
    end
  endtask

  task automatic test_d_write();
    int i0, d0;
    bit to;
    lat = 2;
    i0  = i_pulses;
    d0  = d_pulses;
    exp_beats.push_back('{addr: 32'h0000_0A08, wr: 1'b1, wdata: 32'h1111_1111});
    exp_beats.push_back('{addr: 32'h0000_0A0C, wr: 1'b1, wdata: 32'h2222_2222});
    exp_d_q.push_back(exp_d_line);
    @(negedge CLK);
    d_addr  = 32'h0000_0A0C;
    d_we    = 1'b1;
    d_wdata = 64'h1111_1111_2222_2222;
    d_req   = 1'b1;
    wait_quiet(200, to);
    d_we = 1'b0;
    total++;
    if (to || d_pulses - d0 != 1 || i_pulses != i0) begin
      bad++;
      $display("FAIL d_write_pulses: timeout=%0b d=%0d i=%0d want 0 1 0",
               to, d_pulses - d0, i_pulses - i0);
    end
    total++;
    if (d_line !== exp_d_line || exp_beats.size() != 0) begin
      bad++;
      $display("FAIL d_write_line: got %0h left=%0d want %0h 0", d_line, exp_beats.size(),
               exp_d_line);
    end
  endtask

  task automatic test_zero_wait();
    int n;
    bit to;
    lat = 1;
    push_d_rd(32'h0000_6000);
    @(negedge CLK);
    d_addr = 32'h0000_6004;
    d_we   = 1'b0;
    d_req  = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge CLK);
      n++;
      if (d_dready) break;
    end
    // Grant cycle plus two single-cycle beats precede DONE: third edge after the request.
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL zero_wait_latency: got %0d edges want 3", n);
    end
    wait_quiet(50, to);
    total++;
    if (to || exp_beats.size() != 0) begin
      bad++;
      $display("FAIL zero_wait_done: timeout=%0b left=%0d want 0 0", to, exp_beats.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    int a0, i0, n;
    bit to;
    lat = 3;
    a0  = ack_count;
    i0  = i_pulses;
    for (int k = 0; k < 4; k++) begin
      exp_beats.push_back('{addr: 32'h0000_7000 + 32'(4 * k), wr: 1'b0, wdata: 32'h0});
    end
    @(negedge CLK);
    i_addr = 32'h0000_7000;
    i_req  = 1'b1;
    n = 0;
    while (ack_count < a0 + 2 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h0000_7008) begin
      bad++;
      $display("FAIL mid_burst_beat2: rd=%0b addr=%0h want 1 7008", mem_rd, mem_addr);
    end
    RSTn  = 1'b0;
    i_req = 1'b0;
    @(negedge CLK);
    total++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_ctrl: rd=%0b wr=%0b busy=%0b want 0", mem_rd, mem_wr, busy);
    end
    total++;
    if (i_line !== 128'h0 || d_line !== 64'h0) begin
      bad++;
      $display("FAIL mid_reset_lines: i=%0h d=%0h want 0", i_line, d_line);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    exp_beats.delete();
    exp_i_line = '0;
    exp_d_line = '0;
    @(negedge CLK);
    total++;
    if (i_pulses != i0) begin
      bad++;
      $display("FAIL mid_reset_dready: pulses=%0d want 0", i_pulses - i0);
    end
    push_i(32'h0000_7000);
    @(negedge CLK);
    i_addr = 32'h0000_7004;
    i_req  = 1'b1;
    wait_quiet(200, to);
    total++;
    if (to || i_pulses - i0 != 1 || exp_beats.size() != 0) begin
      bad++;
      $display("FAIL restart_refill: timeout=%0b pulses=%0d left=%0d want 0 1 0",
               to, i_pulses - i0, exp_beats.size());
    end
  endtask

  task automatic test_spurious_ack();
    int i0, d0;
    i0 = i_pulses;
    d0 = d_pulses;
    @(negedge CLK);
    spurious = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL spurious_busy: got %0b want 0", busy);
      end
    end
    spurious = 1'b0;
    repeat (2) @(negedge CLK);
    total++;
    if (i_pulses != i0 || d_pulses != d0) begin
      bad++;
      $display("FAIL spurious_dready: i=%0d d=%0d want 0 0", i_pulses - i0, d_pulses - d0);
    end
    total++;
    if (i_line !== exp_i_line || d_line !== exp_d_line) begin
      bad++;
      $display("FAIL spurious_lines: i=%0h d=%0h want %0h %0h", i_line, d_line, exp_i_line,
               exp_d_line);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    lat        = 3;
    ack_count  = 0;
    spurious   = 1'b0;
    exp_i_line = '0;
    exp_d_line = '0;
    RSTn       = 1'b0;
    i_req      = 1'b0;
    i_addr     = '0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    test_reset();
    test_tie();
    test_i_refill();
    test_d_write();
    test_zero_wait();
    test_spurious_ack();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter: MEM_LATENCY, 20, nominal cycles from strobe to mem_ack; used by the bench model only, no RTL effect.
REQ-002 SHALL have port: CLK  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: RSTn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: i_req  input  1  iCache miss request, level, held until i_dready.
REQ-005 SHALL have port: i_addr  input  32  iCache miss address.
REQ-006 SHALL have port: i_line  output  128  refilled iCache line, word at offset 0 in [127:96].
REQ-007 SHALL have port: i_dready  output  1  one-cycle pulse, i_line valid.
REQ-008 SHALL have port: d_req  input  1  dCache request, level, held until d_dready.
REQ-009 SHALL have port: d_we  input  1  1 = writeback of d_wdata, 0 = refill.
REQ-010 SHALL have port: d_addr  input  32  dCache address.
REQ-011 SHALL have port: d_wdata  input  64  writeback block, offset-0 word in [63:32].
REQ-012 SHALL have port: d_line  output  64  refilled dCache block, offset-0 word in [63:32].
REQ-013 SHALL have port: d_dready  output  1  one-cycle pulse, refill or writeback complete.
REQ-014 SHALL have port: mem_addr  output  32  word address to main memory.
REQ-015 SHALL have port: mem_rd / mem_wr  output  1 each  read/write strobes, mutually exclusive.
REQ-016 SHALL have port: mem_wdata  output  32  write word.
REQ-017 SHALL have port: mem_rdata  input  32  read word, valid with mem_ack.
REQ-018 SHALL have port: mem_ack  input  1  beat complete, one cycle.
REQ-019 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-020 SHALL implement FSM IDLE -> BEAT -> DONE -> IDLE.
REQ-021 IDLE: only one req high -> grant it; both high -> grant side opposite last_grant; neither -> stay IDLE.
REQ-022 On grant SHALL latch base address (I: {addr[31:4],4'b0}, 4 beats; D: {addr[31:3],3'b0}, 2 beats), d_we, d_wdata; update last_grant.
REQ-023 BEAT: mem_addr = base + 4*beat; mem_rd (or mem_wr for D write) held high until mem_ack.
REQ-024 On mem_ack during a read SHALL store mem_rdata into word slot beat; increment beat.
REQ-025 Next beat SHALL start the following cycle with no idle gap.
REQ-026 After the final beat's ack SHALL enter DONE.
REQ-027 D write: beat 0 mem_wdata = d_wdata[63:32]; beat 1 = d_wdata[31:0].
REQ-028 DONE: exactly one cycle, pulse granted side's dready, strobes low.
REQ-029 i_line/d_line SHALL hold the last completed refill until the next refill on that side; a D write SHALL leave d_line unchanged.
REQ-030 Requester SHALL drop req by the edge ending DONE; req sampled only in IDLE.
REQ-031 mem_ack outside BEAT SHALL be ignored.
REQ-032 mem_ack in the first strobe cycle SHALL be accepted (zero wait).
REQ-033 Latency = 1 (grant) + sum of beat cycles + 1 (DONE).
REQ-034 Non-granted request SHALL wait, unchanged, until the next IDLE.

Reset
REQ-035 RSTn low at an edge SHALL force IDLE, beat=0, last_grant=I, and zero all outputs and line registers.
REQ-036 Reset mid-burst SHALL discard the partial line with no dready pulse; strobes low the cycle after the reset edge.

Structure
REQ-037 Package cache_mem_pkg SHALL hold the FSM state encoding, I/D line widths (128/64), beat counts (4/2) and grant encoding.
REQ-038 The 2-requester round-robin picker SHALL be sub-module cache_rr_arbiter; the burst FSM and datapath SHALL live in the top.

Verification
REQ-039 I refill alone, ack latency 3: i_addr=0x0000_1234 -> mem_rd at 0x1230,0x1234,0x1238,0x123C; i_line={w0,w1,w2,w3}; i_dready one pulse.
REQ-040 Simultaneous i_req/d_req out of reset -> D granted first, I second; second tie -> D granted again (last_grant=I after the I burst).
REQ-041 D writeback d_addr=0x0000_0A0C, d_wdata=0x11111111_22222222 -> mem_wr 0xA08/0x11111111, 0xA0C/0x22222222; d_line unchanged; d_dready pulses.
REQ-042 Zero-wait memory (ack in the same cycle as strobe) -> D refill completes in 4 cycles from grant edge to DONE.
REQ-043 RSTn low during I beat 2 -> strobes low, no i_dready, i_line=0, next request starts at beat 0.
REQ-044 Spurious mem_ack in IDLE -> no state change, no dready, lines unchanged.
